// File: rtl/uart_tx_fifo_sb_ctrl.sv
// Generic byte FIFO plus the bus-mapped UART transmitter that drains it.
// Latency: bus access completes one cycle after req_i; an idle TX starts a frame two cycles after a DATA write.
// Backpressure: none on the bus; DATA writes to a full FIFO are dropped and recorded in sticky overflow.

// Synchronous FIFO with flush; a push into a full FIFO is taken only when a pop frees a slot in the same cycle.
// Latency: head_dat shows a pushed entry one cycle after the push when the FIFO was empty.
// Backpressure: push_vld while full and not popping is silently ignored; the caller tracks the drop.
module uart_tx_fifo_sb_ctrl_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   resetn_i,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop_rdy && !empty;
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage array; entries need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; flush wins over push/pop.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Bus-mapped buffered UART transmitter: DATA/STATUS/DIV/CTRL/RST registers, FIFO and framing FSM.
// Latency: ready_o and read_data_o one cycle after req_i; tx_o registered, frames back-to-back while data remains.
// Backpressure: never stalls the bus; overflowing DATA writes are dropped and set STATUS.overflow.
module uart_tx_fifo_sb_ctrl #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd868
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state_q, state_d;

    logic [7:0]    reg_off;
    logic          bus_wr, bus_rd, data_wr, div_wr, ctrl_wr, flush, status_rd;
    logic [15:0]   div_q;
    logic          par_en_q, par_odd_q, overflow_q;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    cnt_byte;
    logic [31:0]   rd_mux;
    logic [15:0]   baud_q, baud_d, div_lat_q, div_lat_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_en_lat_q, par_en_lat_d, par_bit_q, par_bit_d;
    logic          tx_d, baud_end;
    logic          unused_bits;

    assign reg_off     = addr_i[7:0];
    assign bus_wr      = req_i && write_enable_i;
    assign bus_rd      = req_i && !write_enable_i;
    assign data_wr     = bus_wr && (reg_off == 8'h00);
    assign div_wr      = bus_wr && (reg_off == 8'h08);
    assign ctrl_wr     = bus_wr && (reg_off == 8'h0C);
    assign flush       = bus_wr && (reg_off == 8'h24) && write_data_i[0];
    assign status_rd   = bus_rd && (reg_off == 8'h04);
    assign cnt_byte    = 8'(fifo_cnt);
    assign busy_o      = (state_q != S_IDLE) || !fifo_empty;
    assign baud_end    = (baud_q == div_lat_q - 16'd1);
    assign unused_bits = ^{addr_i[31:8], write_data_i[31:16]};

    uart_tx_fifo_sb_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .flush    (flush),
        .push_vld (data_wr),
        .push_dat (write_data_i[7:0]),
        .pop_rdy  (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    // Read mux; unmapped offsets and DATA read as zero.
    always_comb begin
        rd_mux = '0;
        case (reg_off)
            8'h04:   rd_mux = {16'h0, cnt_byte, 4'h0, overflow_q, fifo_empty, fifo_full, busy_o};
            8'h08:   rd_mux = {16'h0, div_q};
            8'h0C:   rd_mux = {30'h0, par_odd_q, par_en_q};
            default: rd_mux = '0;
        endcase
    end

    // Bus response: one-cycle ready strobe, read data held until the next read.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            ready_o     <= 1'b0;
            read_data_o <= '0;
        end else begin
            ready_o <= req_i;
            if (bus_rd) read_data_o <= rd_mux;
        end
    end

    // Configuration and sticky overflow; a drop only happens when no pop frees a slot.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            div_q      <= DIV_RST;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (div_wr) div_q <= (write_data_i[15:0] < 16'd4) ? 16'd4 : write_data_i[15:0];
            if (ctrl_wr) begin
                par_en_q  <= write_data_i[0];
                par_odd_q <= write_data_i[1];
            end
            if (flush || status_rd) overflow_q <= 1'b0;
            else if (data_wr && fifo_full && !fifo_pop) overflow_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // FSM next state and pop; a flush aborts the frame and suppresses the pop.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE:   if (!fifo_empty) begin state_d = S_START; fifo_pop = 1'b1; end
            S_START:  if (baud_end) state_d = S_DATA;
            S_DATA:   if (baud_end && bit_cnt_q == 3'd7) state_d = par_en_lat_q ? S_PARITY : S_STOP;
            S_PARITY: if (baud_end) state_d = S_STOP;
            S_STOP: begin
                if (baud_end) begin
                    if (!fifo_empty) begin state_d = S_START; fifo_pop = 1'b1; end
                    else state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            fifo_pop = 1'b0;
        end
    end

    // FSM outputs: frame datapath next values and the line level for the upcoming state.
    always_comb begin
        baud_d = baud_q + 16'd1;
        if (state_d != state_q || baud_end || state_q == S_IDLE) baud_d = '0;
        bit_cnt_d = '0;
        if (state_q == S_DATA) bit_cnt_d = baud_end ? bit_cnt_q + 3'd1 : bit_cnt_q;
        shreg_d      = shreg_q;
        div_lat_d    = div_lat_q;
        par_en_lat_d = par_en_lat_q;
        par_bit_d    = par_bit_q;
        if (fifo_pop) begin
            shreg_d      = fifo_head;
            div_lat_d    = div_q;
            par_en_lat_d = par_en_q;
            par_bit_d    = (^fifo_head) ^ par_odd_q;
        end else if (state_q == S_DATA && baud_end) begin
            shreg_d = {1'b0, shreg_q[7:1]};
        end
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_bit_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // Frame datapath registers; tx_o changes on the same edge as the state.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            baud_q       <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            div_lat_q    <= DIV_RST;
            par_en_lat_q <= 1'b0;
            par_bit_q    <= 1'b0;
            tx_o         <= 1'b1;
        end else begin
            baud_q       <= baud_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            div_lat_q    <= div_lat_d;
            par_en_lat_q <= par_en_lat_d;
            par_bit_q    <= par_bit_d;
            tx_o         <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_sb_ctrl.sv
module tb_uart_tx_fifo_sb_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        tx;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic v; int d; } seg_t;
    seg_t exp_q[$];

    typedef struct { logic w; logic [7:0] off; logic [31:0] d; logic [31:0] e; } vec_t;
    vec_t tbl[21];

    logic [7:0] ovb[10];

    uart_tx_fifo_sb_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_RST(16'd868)) dut (
        .clk_i          (clk),
        .resetn_i       (rst_n),
        .req_i          (req),
        .write_enable_i (we),
        .addr_i         (addr),
        .write_data_i   (wdata),
        .read_data_o    (rdata),
        .ready_o        (ready),
        .tx_o           (tx),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int clamp_div(input logic [15:0] v);
        return (v < 16'd4) ? 4 : int'(v);
    endfunction

    // Reference line model: start 0, 8 data bits LSB first, optional parity, stop 1.
    function automatic void add_frame(input logic [7:0] b, input int d, input logic pen, input logic podd);
        seg_t s;
        s.d = d;
        s.v = 1'b0; exp_q.push_back(s);
        for (int i = 0; i < 8; i++) begin s.v = b[i]; exp_q.push_back(s); end
        if (pen) begin s.v = (^b) ^ podd; exp_q.push_back(s); end
        s.v = 1'b1; exp_q.push_back(s);
    endfunction

    task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        req = 1'b1; we = w; addr = {24'h0, off}; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("ready_pulse", 32'(ready), 32'd1);
        r = rdata;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] x;
        bus(1'b1, off, d, x);
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] off, input logic [31:0] e);
        logic [31:0] x;
        bus(1'b0, off, 32'h0, x);
        chk(nm, x, e);
    endtask

    // Waits for the start bit, then checks every expected bit for its full duration.
    task automatic check_line(input string nm);
        int t;
        int bad;
        logic last;
        bit first;
        t = 0;
        first = 1'b1;
        while (tx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) begin
            n_vec++; n_err++;
            $display("FAIL %s start: tx_o stayed %b for 400 cycles, expected a start bit", nm, tx);
            exp_q.delete();
            return;
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            bad = 0;
            last = exp_q[i].v;
            for (int k = 0; k < exp_q[i].d; k++) begin
                if (!first) @(negedge clk);
                first = 1'b0;
                if (tx !== exp_q[i].v) begin bad++; last = tx; end
            end
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL %s bit %0d: tx_o=%b in %0d cycles, expected %b", nm, i, last, bad, exp_q[i].v);
            end
        end
        exp_q.delete();
    endtask

    task automatic idle_chk(input string nm);
        @(negedge clk);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            '{1'b0, 8'h04, 32'h0,        32'h0000_0004},
            '{1'b0, 8'h00, 32'h0,        32'h0},
            '{1'b0, 8'h08, 32'h0,        32'h0000_0364},
            '{1'b0, 8'h0C, 32'h0,        32'h0},
            '{1'b0, 8'h10, 32'h0,        32'h0},
            '{1'b1, 8'h08, 32'h1,        32'h0},
            '{1'b0, 8'h08, 32'h0,        32'h4},
            '{1'b1, 8'h08, 32'hFFFF1234, 32'h0},
            '{1'b0, 8'h08, 32'h0,        32'h1234},
            '{1'b1, 8'h0C, 32'hFFFFFFFF, 32'h0},
            '{1'b0, 8'h0C, 32'h0,        32'h3},
            '{1'b1, 8'h10, 32'h5A5A,     32'h0},
            '{1'b0, 8'h10, 32'h0,        32'h0},
            '{1'b0, 8'h08, 32'h0,        32'h1234},
            '{1'b1, 8'h08, 32'h3,        32'h0},
            '{1'b0, 8'h08, 32'h0,        32'h4},
            '{1'b1, 8'h08, 32'h5,        32'h0},
            '{1'b0, 8'h08, 32'h0,        32'h5},
            '{1'b1, 8'h0C, 32'h0,        32'h0},
            '{1'b0, 8'h0C, 32'h0,        32'h0},
            '{1'b0, 8'h04, 32'h0,        32'h0000_0004}
        };

        // Reset state
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd_chk("rst_status", 8'h04, 32'h4);
        @(negedge clk);
        chk("ready_drop", 32'(ready), 32'd0);

        // Register map table
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].w) wr(tbl[i].off, tbl[i].d);
            else rd_chk($sformatf("tbl[%0d]", i), tbl[i].off, tbl[i].e);
        end

        // Plain frame 0x55
        wr(8'h08, 32'd4); wr(8'h0C, 32'd0);
        add_frame(8'h55, 4, 1'b0, 1'b0);
        fork check_line("f55"); wr(8'h00, 32'h55); join
        idle_chk("f55_end");

        // Even then odd parity on 0x07
        wr(8'h0C, 32'd1);
        add_frame(8'h07, 4, 1'b1, 1'b0);
        fork check_line("par_even"); wr(8'h00, 32'h07); join
        idle_chk("par_even_end");
        wr(8'h0C, 32'd3);
        add_frame(8'h07, 4, 1'b1, 1'b1);
        fork check_line("par_odd"); wr(8'h00, 32'h07); join
        idle_chk("par_odd_end");

        // Burst of 10: one in flight plus DEPTH buffered, the rest dropped
        wr(8'h0C, 32'd0);
        for (int i = 0; i < 10; i++) ovb[i] = 8'($urandom);
        for (int i = 0; i < DEPTH + 1; i++) add_frame(ovb[i], 4, 1'b0, 1'b0);
        fork
            check_line("burst");
            begin
                @(negedge clk);
                req = 1'b1; we = 1'b1; addr = 32'h0;
                for (int i = 0; i < 10; i++) begin wdata = {24'h0, ovb[i]}; @(negedge clk); end
                req = 1'b0; we = 1'b0;
                rd_chk("status_ovf", 8'h04, {16'h0, 8'(DEPTH), 8'h0B});
                rd_chk("status_ovf_clr", 8'h04, {16'h0, 8'(DEPTH), 8'h03});
            end
        join
        idle_chk("burst_end");

        // DIV written mid-frame applies from the next frame
        add_frame(8'h3C, 4, 1'b0, 1'b0);
        add_frame(8'hC3, 6, 1'b0, 1'b0);
        fork
            check_line("divchg");
            begin wr(8'h00, 32'h3C); wr(8'h00, 32'hC3); wr(8'h08, 32'd6); end
        join
        idle_chk("divchg_end");
        wr(8'h08, 32'd4);

        // Soft flush mid-frame
        wr(8'h0C, 32'd1);
        wr(8'h00, 32'h00);
        repeat (12) @(negedge clk);
        chk("pre_flush_tx", 32'(tx), 32'd0);
        wr(8'h24, 32'd1);
        chk("flush_tx", 32'(tx), 32'd1);
        rd_chk("flush_status", 8'h04, 32'h4);
        rd_chk("flush_ctrl", 8'h0C, 32'h1);
        rd_chk("flush_div", 8'h08, 32'h4);
        add_frame(8'hA5, 4, 1'b1, 1'b0);
        fork check_line("after_flush"); wr(8'h00, 32'hA5); join
        idle_chk("after_flush_end");

        // Randomized frames against the line model
        for (int it = 0; it < 16; it++) begin
            logic [15:0] dv;
            logic [1:0]  ct;
            int          nb;
            logic [7:0]  b[4];
            dv = 16'($urandom_range(0, 7));
            ct = 2'($urandom_range(0, 3));
            nb = $urandom_range(1, 4);
            wr(8'h08, {16'h0, dv});
            wr(8'h0C, {30'h0, ct});
            rd_chk("rnd_div", 8'h08, 32'(clamp_div(dv)));
            rd_chk("rnd_ctrl", 8'h0C, {30'h0, ct});
            for (int j = 0; j < nb; j++) begin
                b[j] = 8'($urandom);
                add_frame(b[j], clamp_div(dv), ct[0], ct[1]);
            end
            fork
                check_line("rnd");
                begin for (int j = 0; j < nb; j++) wr(8'h00, {24'h0, b[j]}); end
            join
            idle_chk("rnd_end");
        end

        // Asynchronous reset during a data bit
        wr(8'h08, 32'd1);
        rd_chk("div_clamp", 8'h08, 32'h4);
        wr(8'h00, 32'h00);
        repeat (10) @(negedge clk);
        chk("pre_arst_tx", 32'(tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("arst_div", 8'h08, 32'h364);
        rd_chk("arst_status", 8'h04, 32'h4);
        rd_chk("arst_ctrl", 8'h0C, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_sb_ctrl.md
Name: uart_tx_fifo_sb_ctrl

Overview:
- Buffered UART transmitter slave on the system bus. It sits downstream of the LSU's peripheral decode, in the 0x06xx_xxxx slot beside the timer and UART RX controllers.
- The core writes bytes into an internal FIFO. A framing FSM serialises them on tx_o with a programmable divisor and optional parity.
- It replaces the unbuffered TX controller, so firmware no longer polls busy for every byte.

Parameters:
- FIFO_DEPTH, 8, byte entries; power of 2, minimum 2.
- DIV_RST, 16'd868, reset value of the clocks-per-bit divisor.

Ports:
- clk_i  input  1  system clock (sysclk domain).
- resetn_i  input  1  asynchronous active-low reset.
- req_i  input  1  bus request, already qualified by the address decoder.
- write_enable_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte offset; bits [31:24] are zero, only [7:0] are decoded.
- write_data_i  input  32  write data.
- read_data_o  output  32  registered read data.
- ready_o  output  1  access-complete strobe.
- tx_o  output  1  UART serial line, idle high.
- busy_o  output  1  FSM not IDLE, or FIFO not empty.

Behaviour:
- One clock: clk_i. Reset: resetn_i, asynchronous, active-low.
- Reset values: read_data_o=0, ready_o=0, tx_o=1, busy_o=0. FIFO empty, overflow=0, divisor=DIV_RST, parity_en=0, parity_odd=0, FSM=IDLE.
- Register map (word offsets):
  - 0x00 DATA: W pushes write_data_i[7:0]; R returns 0.
  - 0x04 STATUS: R = {count[27:8 zero-ext as needed], 4'b0, overflow, empty, full, busy}. Exact layout: bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits[15:8] count. Reading it clears overflow.
  - 0x08 DIV: R/W, bits[15:0]. Written values below 4 are stored as 4.
  - 0x0C CTRL: R/W. bit0 parity_en, bit1 parity_odd.
  - 0x24 RST: W with bit0=1 flushes the FIFO, aborts the frame, tx_o=1 on the next cycle, overflow=0. DIV and CTRL are kept.
  - Unmapped: reads return 0, writes are ignored.
- Bus timing:
  - ready_o pulses for exactly one cycle, the cycle after any req_i.
  - read_data_o is valid in that same cycle and holds its value until the next read.
  - Back-to-back requests on consecutive cycles are accepted.
- FIFO push rules:
  - A DATA write is accepted if the FIFO is not full, or if the FSM pops in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- FSM: IDLE → START → DATA → (PARITY if parity_en) → STOP → IDLE or START.
  - IDLE: if the FIFO is not empty, pop the head into a shift register and latch div and ctrl into frame-local copies, then go to START on the next cycle.
  - Every non-IDLE state lasts exactly div_latched clocks, using a baud counter that runs 0..div-1.
  - START: tx_o=0.
  - DATA: 8 bits, LSB first, with a 3-bit bit counter.
  - PARITY: even parity is XOR of the data bits; odd parity is its inverse.
  - STOP: tx_o=1 for one bit time. At the end of STOP, if the FIFO is not empty, pop and go straight to START, so there is no idle gap between frames.
- tx_o is driven from a register, so it has no combinational glitches.
- Writes to DIV or CTRL during a frame take effect from the next frame.
- A RST write takes priority over a DATA write in the same cycle. It cannot occur on the same bus cycle, but internal order is flush first.
- Asynchronous reset mid-frame: tx_o goes to 1 immediately and all state returns to its reset values.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then read STATUS → 0x0000_0004 (empty). tx_o=1, ready_o pulses 1 cycle after req.
- Write DIV=4, CTRL=0, DATA=0x55 → tx_o = 0, 1,0,1,0,1,0,1,0, 1 with 4 clocks per bit (40 clocks). busy_o falls right after the stop bit.
- DIV=4, CTRL=0b01, DATA=0x07 → parity bit 1 after data, frame is 44 clocks. Repeat with CTRL=0b11 → parity bit 0.
- Write 10 bytes back-to-back with DEPTH=8 while the first frame has just popped:
  - 9 bytes are accepted, 1 is dropped.
  - STATUS shows overflow=1, full=1; a second read shows overflow=0.
  - Frames on tx_o are contiguous, with no idle gap.
- Mid-frame: write RST=1 → tx_o=1 next cycle, STATUS=0x04. Then DATA=0xA5 → a clean new frame.
- Write DIV=1 → reads back 4. Assert resetn_i low during a DATA bit → tx_o=1 asynchronously, DIV returns to 868.
